// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared definitions for the control unit.
//   - opcode constants (HLT..POP)
//   - FSM state encodings (0-15)
//   - flag bit indices into flags = {O,C,N,Z}
//   - registered output bundle and its per-state (Moore) decode
// Configuration macro (used in cu_decoder): CU_ILLEGAL_HALT_EN
package control_unit_pkg;

    localparam logic [5:0] OP_HLT = 6'd0;
    localparam logic [5:0] OP_LDA = 6'd1;
    localparam logic [5:0] OP_STA = 6'd2;
    localparam logic [5:0] OP_BRZ = 6'd3;
    localparam logic [5:0] OP_BRN = 6'd4;
    localparam logic [5:0] OP_BRC = 6'd5;
    localparam logic [5:0] OP_BRO = 6'd6;
    localparam logic [5:0] OP_BRA = 6'd7;
    localparam logic [5:0] OP_JMP = 6'd8;
    localparam logic [5:0] OP_RET = 6'd9;
    localparam logic [5:0] OP_ADD = 6'd10;
    localparam logic [5:0] OP_SUB = 6'd11;
    localparam logic [5:0] OP_LSR = 6'd12;
    localparam logic [5:0] OP_LSL = 6'd13;
    localparam logic [5:0] OP_RSR = 6'd14;
    localparam logic [5:0] OP_RSL = 6'd15;
    localparam logic [5:0] OP_MOV = 6'd16;
    localparam logic [5:0] OP_MUL = 6'd17;
    localparam logic [5:0] OP_DIV = 6'd18;
    localparam logic [5:0] OP_MOD = 6'd19;
    localparam logic [5:0] OP_AND = 6'd20;
    localparam logic [5:0] OP_OR  = 6'd21;
    localparam logic [5:0] OP_XOR = 6'd22;
    localparam logic [5:0] OP_NOT = 6'd23;
    localparam logic [5:0] OP_CMP = 6'd24;
    localparam logic [5:0] OP_TST = 6'd25;
    localparam logic [5:0] OP_INC = 6'd26;
    localparam logic [5:0] OP_DEC = 6'd27;
    localparam logic [5:0] OP_PSH = 6'd28;
    localparam logic [5:0] OP_POP = 6'd29;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_O = 3;

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StLdy   = 4'd1,
        StLdx   = 4'd2,
        StStr   = 4'd3,
        StBrnT  = 4'd4,
        StAlu   = 4'd5,
        StMoviy = 4'd6,
        StMovay = 4'd7,
        StMovix = 4'd8,
        StMovax = 4'd9,
        StPsh   = 4'd10,
        StPopy  = 4'd11,
        StPopx  = 4'd12,
        StHlt   = 4'd13,
        StNop   = 4'd14,
        StStall = 4'd15
    } state_e;

    typedef struct packed {
        logic move;
        logic store;
        logic branch;
        logic pop;
        logic push;
        logic stall;
        logic str_rez;
        logic load_y;
        logic load_x;
        logic acc_opx;
        logic acc_opy;
        logic done;
        logic reset_cu;
    } cu_out_t;

    function automatic cu_out_t state_outputs(input state_e s);
        cu_out_t o;
        o = '0;
        case (s)
            StIdle:  o.reset_cu = 1'b1;
            StLdy:   o.load_y   = 1'b1;
            StLdx:   o.load_x   = 1'b1;
            StStr:   o.store    = 1'b1;
            StBrnT:  o.branch   = 1'b1;
            StAlu:   o.str_rez  = 1'b1;
            StMoviy: begin o.acc_opy = 1'b1; o.move = 1'b1; o.str_rez = 1'b1; end
            StMovay: o.acc_opy  = 1'b1;
            StMovix: begin o.acc_opx = 1'b1; o.move = 1'b1; o.str_rez = 1'b1; end
            StMovax: o.acc_opx  = 1'b1;
            StPsh:   begin o.store = 1'b1; o.push = 1'b1; end
            StPopy:  begin o.load_y = 1'b1; o.pop = 1'b1; end
            StPopx:  begin o.load_x = 1'b1; o.pop = 1'b1; end
            StHlt:   o.done     = 1'b1;
            StNop:   o = '0;
            StStall: o.stall    = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: combinational instruction decode to the target FSM state.
// Ports:
//   i_opcode  [5:0] instruction opcode
//   i_reg_s         register select (0=X, 1=Y)
//   i_acc_s         MOV source (0=immediate, 1=accumulator)
//   i_flags   [3:0] {O,C,N,Z}, sampled with the opcode (no storage)
//   o_state   [3:0] decoded target state
// Macro CU_ILLEGAL_HALT_EN: when defined, opcodes 30-63 halt instead of NOP.
module cu_decoder
    import control_unit_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic       i_reg_s,
    input  logic       i_acc_s,
    input  logic [3:0] i_flags,
    output state_e     o_state
);

    always_comb begin
        o_state = StNop;
        case (i_opcode)
            OP_HLT: o_state = StHlt;
            OP_LDA: o_state = i_reg_s ? StLdy : StLdx;
            OP_STA: o_state = StStr;
            OP_BRZ: o_state = i_flags[FLAG_Z] ? StBrnT : StNop;
            OP_BRN: o_state = i_flags[FLAG_N] ? StBrnT : StNop;
            OP_BRC: o_state = i_flags[FLAG_C] ? StBrnT : StNop;
            OP_BRO: o_state = i_flags[FLAG_O] ? StBrnT : StNop;
            OP_BRA: o_state = StBrnT;
            OP_JMP, OP_RET: o_state = StNop;
            OP_ADD, OP_SUB, OP_LSR, OP_LSL, OP_RSR, OP_RSL,
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_INC, OP_DEC: o_state = StAlu;
            OP_MOV: begin
                case ({i_reg_s, i_acc_s})
                    2'b00:   o_state = StMovix;
                    2'b01:   o_state = StMovax;
                    2'b10:   o_state = StMoviy;
                    default: o_state = StMovay;
                endcase
            end
            OP_MUL, OP_DIV, OP_MOD: o_state = StStall;
            OP_CMP, OP_TST: o_state = StNop;
            OP_PSH: o_state = StPsh;
            OP_POP: o_state = i_reg_s ? StPopy : StPopx;
            default: begin
`ifdef CU_ILLEGAL_HALT_EN
                o_state = StHlt;
`else
                o_state = StNop;
`endif
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing one instruction per clock.
// Ports:
//   clk, reset (async, active-low)
//   opcode[5:0], reg_s, acc_s, flags[3:0]  instruction inputs, decoded by cu_decoder
//   start      leave IDLE;  ALU_ready  releases STALL
//   move, store, branch, pop, push, stall, str_rez, load_y, load_x,
//   acc_opx, acc_opy, done, reset_cu   registered per-state outputs
//   state[3:0] current FSM state
// Macro CU_ILLEGAL_HALT_EN (see cu_decoder) selects HLT vs NOP for opcodes 30-63.
module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       reg_s,
    input  logic       acc_s,
    input  logic       start,
    input  logic       ALU_ready,
    input  logic [3:0] flags,
    output logic       move,
    output logic       store,
    output logic       branch,
    output logic       pop,
    output logic       push,
    output logic       stall,
    output logic       str_rez,
    output logic       load_y,
    output logic       load_x,
    output logic       acc_opx,
    output logic       acc_opy,
    output logic       done,
    output logic       reset_cu,
    output logic [3:0] state
);

    state_e  w_decoded;
    state_e  w_next;
    state_e  r_state;
    cu_out_t r_out;

    cu_decoder u_decoder (
        .i_opcode (opcode),
        .i_reg_s  (reg_s),
        .i_acc_s  (acc_s),
        .i_flags  (flags),
        .o_state  (w_decoded)
    );

    always_comb begin
        w_next = w_decoded;
        case (r_state)
            StIdle:  w_next = start ? w_decoded : StIdle;
            StHlt:   w_next = StIdle;
            StStall: w_next = ALU_ready ? w_decoded : StStall;
            default: w_next = w_decoded;
        endcase
    end

    // Outputs are registered from the next state so they stay aligned with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_out   <= state_outputs(StIdle);
        end else begin
            r_state <= w_next;
            r_out   <= state_outputs(w_next);
        end
    end

    assign state    = r_state;
    assign move     = r_out.move;
    assign store    = r_out.store;
    assign branch   = r_out.branch;
    assign pop      = r_out.pop;
    assign push     = r_out.push;
    assign stall    = r_out.stall;
    assign str_rez  = r_out.str_rez;
    assign load_y   = r_out.load_y;
    assign load_x   = r_out.load_x;
    assign acc_opx  = r_out.acc_opx;
    assign acc_opy  = r_out.acc_opy;
    assign done     = r_out.done;
    assign reset_cu = r_out.reset_cu;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven directed check of control_unit plus hand-written
// reset/stall sequences. Output vector order:
// {move,store,branch,pop,push,stall,str_rez,load_y,load_x,acc_opx,acc_opy,done,reset_cu}
module tb_control_unit;

    localparam logic [12:0] O_IDLE  = 13'h0001;
    localparam logic [12:0] O_LDY   = 13'h0020;
    localparam logic [12:0] O_LDX   = 13'h0010;
    localparam logic [12:0] O_STR   = 13'h0800;
    localparam logic [12:0] O_BRN   = 13'h0400;
    localparam logic [12:0] O_ALU   = 13'h0040;
    localparam logic [12:0] O_MOVIY = 13'h1044;
    localparam logic [12:0] O_MOVAY = 13'h0004;
    localparam logic [12:0] O_MOVIX = 13'h1048;
    localparam logic [12:0] O_MOVAX = 13'h0008;
    localparam logic [12:0] O_PSH   = 13'h0900;
    localparam logic [12:0] O_POPY  = 13'h0220;
    localparam logic [12:0] O_POPX  = 13'h0210;
    localparam logic [12:0] O_HLT   = 13'h0002;
    localparam logic [12:0] O_NOP   = 13'h0000;
    localparam logic [12:0] O_STALL = 13'h0080;

`ifdef CU_ILLEGAL_HALT_EN
    localparam logic [3:0]  ILL_ST  = 4'd13;
    localparam logic [12:0] ILL_OUT = O_HLT;
`else
    localparam logic [3:0]  ILL_ST  = 4'd14;
    localparam logic [12:0] ILL_OUT = O_NOP;
`endif

    typedef struct {
        logic        start;
        logic        alu_ready;
        logic [7:0]  ibyte;   // {opcode, reg_s, acc_s}
        logic [3:0]  flags;
        logic [3:0]  exp_state;
        logic [12:0] exp_out;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [5:0] opcode;
    logic reg_s, acc_s, start, ALU_ready;
    logic [3:0] flags;
    logic move, store, branch, pop, push, stall, str_rez, load_y, load_x;
    logic acc_opx, acc_opy, done, reset_cu;
    logic [3:0] state;
    logic [12:0] w_out;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    control_unit dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .reg_s     (reg_s),
        .acc_s     (acc_s),
        .start     (start),
        .ALU_ready (ALU_ready),
        .flags     (flags),
        .move      (move),
        .store     (store),
        .branch    (branch),
        .pop       (pop),
        .push      (push),
        .stall     (stall),
        .str_rez   (str_rez),
        .load_y    (load_y),
        .load_x    (load_x),
        .acc_opx   (acc_opx),
        .acc_opy   (acc_opy),
        .done      (done),
        .reset_cu  (reset_cu),
        .state     (state)
    );

    assign w_out = {move, store, branch, pop, push, stall, str_rez, load_y, load_x,
                    acc_opx, acc_opy, done, reset_cu};

    function automatic vec_t mk(input logic st, input logic rdy, input logic [7:0] b,
                                input logic [3:0] f, input logic [3:0] es,
                                input logic [12:0] eo);
        vec_t v;
        v.start = st; v.alu_ready = rdy; v.ibyte = b; v.flags = f;
        v.exp_state = es; v.exp_out = eo;
        return v;
    endfunction

    task automatic drive(input logic st, input logic rdy, input logic [7:0] b,
                         input logic [3:0] f);
        start = st; ALU_ready = rdy;
        opcode = b[7:2]; reg_s = b[1]; acc_s = b[0];
        flags = f;
    endtask

    task automatic check(input string name, input logic [3:0] es, input logic [12:0] eo);
        checks++;
        if (state !== es) begin
            failures++;
            $display("FAIL %s state: got %0d expected %0d", name, state, es);
        end
        checks++;
        if (w_out !== eo) begin
            failures++;
            $display("FAIL %s outputs: got %013b expected %013b", name, w_out, eo);
        end
    endtask

    initial begin
        // Table; first row follows reset release.
        vecs.push_back(mk(1, 0, 8'h04, 4'h0, 4'd2,  O_LDX));   // LDA X
        vecs.push_back(mk(1, 0, 8'h0C, 4'h0, 4'd14, O_NOP));   // BRZ not taken
        vecs.push_back(mk(1, 0, 8'h0C, 4'h1, 4'd4,  O_BRN));   // BRZ taken
        vecs.push_back(mk(1, 0, 8'h0C, 4'hE, 4'd14, O_NOP));   // BRZ, other flags only
        vecs.push_back(mk(1, 0, 8'h14, 4'h4, 4'd4,  O_BRN));   // BRC taken
        vecs.push_back(mk(1, 0, 8'h10, 4'h2, 4'd4,  O_BRN));   // BRN taken
        vecs.push_back(mk(1, 0, 8'h18, 4'h7, 4'd14, O_NOP));   // BRO not taken
        vecs.push_back(mk(1, 0, 8'h18, 4'h8, 4'd4,  O_BRN));   // BRO taken
        vecs.push_back(mk(0, 0, 8'h1C, 4'h0, 4'd4,  O_BRN));   // BRA, start ignored
        vecs.push_back(mk(0, 0, 8'h20, 4'hF, 4'd14, O_NOP));   // JMP
        vecs.push_back(mk(0, 0, 8'h40, 4'h0, 4'd8,  O_MOVIX));
        vecs.push_back(mk(0, 0, 8'h42, 4'h0, 4'd6,  O_MOVIY));
        vecs.push_back(mk(0, 0, 8'h41, 4'h0, 4'd9,  O_MOVAX));
        vecs.push_back(mk(0, 0, 8'h43, 4'h0, 4'd7,  O_MOVAY));
        vecs.push_back(mk(0, 0, 8'h44, 4'h0, 4'd15, O_STALL)); // MUL
        vecs.push_back(mk(0, 0, 8'h28, 4'h0, 4'd15, O_STALL));
        vecs.push_back(mk(0, 0, 8'h28, 4'h0, 4'd15, O_STALL));
        vecs.push_back(mk(0, 0, 8'h28, 4'h0, 4'd15, O_STALL));
        vecs.push_back(mk(0, 1, 8'h28, 4'h0, 4'd5,  O_ALU));   // ADD after ready
        vecs.push_back(mk(0, 0, 8'h68, 4'h0, 4'd5,  O_ALU));   // INC
        vecs.push_back(mk(0, 0, 8'h5C, 4'h0, 4'd5,  O_ALU));   // NOT
        vecs.push_back(mk(0, 0, 8'h60, 4'h0, 4'd14, O_NOP));   // CMP
        vecs.push_back(mk(0, 0, 8'h70, 4'h0, 4'd10, O_PSH));
        vecs.push_back(mk(0, 0, 8'h76, 4'h0, 4'd11, O_POPY));
        vecs.push_back(mk(0, 0, 8'h74, 4'h0, 4'd12, O_POPX));
        vecs.push_back(mk(0, 0, 8'h06, 4'h0, 4'd1,  O_LDY));
        vecs.push_back(mk(0, 0, 8'h08, 4'h0, 4'd3,  O_STR));
        vecs.push_back(mk(0, 0, 8'h00, 4'h0, 4'd13, O_HLT));
        vecs.push_back(mk(0, 0, 8'h04, 4'h0, 4'd0,  O_IDLE));  // HLT -> IDLE
        vecs.push_back(mk(0, 0, 8'h04, 4'h0, 4'd0,  O_IDLE));  // waits for start
        vecs.push_back(mk(1, 0, 8'hFC, 4'h0, ILL_ST, ILL_OUT)); // illegal opcode 63

        reset = 1'b0;
        drive(1, 0, 8'h04, 4'h0);
        #12;
        check("reset_hold", 4'd0, O_IDLE);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].start, vecs[i].alu_ready, vecs[i].ibyte, vecs[i].flags);
            @(posedge clk);
            #1;
            check($sformatf("row%0d_%02h", i, vecs[i].ibyte), vecs[i].exp_state, vecs[i].exp_out);
        end

        // Re-enter from a known IDLE, then async reset while stalled.
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        check("reset_from_any", 4'd0, O_IDLE);
        @(negedge clk);
        drive(1, 0, 8'h44, 4'h0);
        @(posedge clk);
        #1;
        check("stall_enter", 4'd15, O_STALL);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_in_stall", 4'd0, O_IDLE);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", 4'd0, O_IDLE);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1, 8'h28, 4'h0);
        @(posedge clk);
        #1;
        check("idle_after_reset", 4'd0, O_IDLE);
        @(negedge clk);
        drive(1, 0, 8'h30, 4'h0);   // LSR with ALU_ready=0
        @(posedge clk);
        #1;
        check("alu_ignores_ready", 4'd5, O_ALU);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
